// File: rtl/psum_deskew.sv
// psum_deskew: re-aligns the skewed partial sums leaving the bottom row of the
// systolic array into whole result rows, buffers them in a small FIFO and
// presents them downstream.
//
// Downstream handshake: a row transfers in every cycle where out_valid and
// out_ready are both high. out_valid and out_row are registers and never depend
// on out_ready in the same cycle. Upstream has no ready: a row arriving while
// the FIFO is full and not popping is dropped and flagged on the sticky
// overflow output.
module psum_deskew #(
  parameter int DATA_WIDTH = 16,
  parameter int COLS       = 4,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [COLS*DATA_WIDTH-1:0] in_psum,
  output logic [COLS*DATA_WIDTH-1:0] out_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       tile_done,
  output logic                       busy,
  output logic                       overflow
);

  localparam int W  = COLS * DATA_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  // Deskew: column j arrives j cycles after column 0, so it is delayed by
  // COLS-1-j cycles to line up with the last column, which is used directly.
  logic [W-1:0] aligned_row;

  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = in_psum[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly_q [D];
      // Per-column delay line
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < D; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= in_psum[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = dly_q[D-1];
    end
  end

  // Row-valid travels alongside column 0 so it marks the aligned cycle.
  logic [COLS-2:0] vld_q;
  logic            aligned_vld;

  // Valid shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < COLS - 1; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign aligned_vld = vld_q[COLS-2];

  // FIFO state and registered outputs
  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [W-1:0]  out_row_q, out_row_d;
  logic          out_valid_q, out_valid_d;
  logic          tile_done_q, tile_done_d;
  logic          overflow_q, overflow_d;
  logic          pop, push, drop, full;

  // Next-state for pointers, occupancy, head register and status
  always_comb begin
    full        = (cnt_q == FULL_CNT);
    pop         = out_valid_q & out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    push        = aligned_vld & (~full | pop);
    drop        = aligned_vld & full & ~pop;

    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    out_valid_d = (cnt_d != '0);
    // Head for next cycle: the row being written becomes the head only when
    // the FIFO would otherwise be empty after this cycle's pop.
    out_row_d = '0;
    if (cnt_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) out_row_d = aligned_row;
      else                                out_row_d = mem_q[rd_ptr_d];
    end

    row_cnt_d   = row_cnt_q;
    tile_done_d = 1'b0;
    if (pop) begin
      if (row_cnt_q == LAST_ROW) begin
        row_cnt_d   = '0;
        tile_done_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + RW'(1);
      end
    end

    overflow_d = overflow_q | drop;
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      row_cnt_q   <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      tile_done_q <= tile_done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Row storage; contents are only meaningful under the occupancy count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= aligned_row;
  end

  assign out_row   = out_row_q;
  assign out_valid = out_valid_q;
  assign tile_done = tile_done_q;
  assign overflow  = overflow_q;
  assign busy      = (|vld_q) | out_valid_q;

endmodule

// File: doc/psum_deskew.md
# psum_deskew

Output-side collector for the systolic matrix-multiply array. It captures the skewed partial sums leaving the bottom `out_down` ports of the last row of processing elements, where column j lags column 0 by j cycles, and re-aligns them into whole result rows. It buffers those rows in a small FIFO and hands them downstream over a valid/ready handshake. Tile-completion and overflow status are reported to the array controller.

## Interface

- `DATA_WIDTH`, 16, width of one partial sum; matches the PE data width.
- `COLS`, 4, number of array columns (≥2).
- `ROWS`, 4, result rows per tile; sets the `tile_done` period (≥1).
- `FIFO_DEPTH`, 4, aligned-row FIFO entries (power of 2, ≥2).
- `clk` input 1, single clock; all state updates on the rising edge.
- `reset` input 1, asynchronous, active-low; clears all state immediately.
- `in_valid` input 1, high in cycle c means column 0 of `in_psum` holds a valid result row element in cycle c.
- `in_psum` input COLS*DATA_WIDTH, flattened bottom-row `out_down` buses; column j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
- `out_row` output COLS*DATA_WIDTH, aligned row at FIFO head, same column packing; all zeros when the FIFO is empty.
- `out_valid` output 1, FIFO non-empty.
- `out_ready` input 1, downstream accepts `out_row` when `out_valid && out_ready`.
- `tile_done` output 1, one-cycle pulse on the handshake that pops the ROWS-th row of a tile.
- `busy` output 1, any valid row in the deskew pipeline or the FIFO.
- `overflow` output 1, sticky; set when an aligned row is dropped.

## Operation

- Skew contract: for an `in_valid` in cycle c, column j is valid in cycle c+j. The array has no stall; the block never backpressures upstream.
- Deskew: column j passes through COLS-1-j register stages, so column COLS-1 is unregistered. `in_valid` passes through a COLS-1 stage valid shift register. In cycle c+COLS-1 all columns of the row are aligned.
- Push: an aligned valid row is written into the FIFO at the end of cycle c+COLS-1.
- Pop: occurs when `out_valid && out_ready`. The head advances and pointers wrap modulo FIFO_DEPTH. An occupancy counter runs 0..FIFO_DEPTH.
- Full with push and no pop: the row is dropped, FIFO contents are unchanged, and `overflow` is set until reset.
- Full with simultaneous push and pop: both occur and the row is accepted; occupancy stays FIFO_DEPTH.
- Empty with push: the row is written, and `out_valid` rises the next cycle; there is no fall-through.
- Row counter runs 0..ROWS-1 and increments on each pop. On a pop at ROWS-1 it wraps to 0 and pulses `tile_done`.
- `busy` = OR of the valid shift register stages OR FIFO non-empty.
- Arithmetic: data passes unmodified. No saturation or extension is applied.

## Timing

- Reset values: `out_row`=0, `out_valid`=0, `tile_done`=0, `busy`=0, `overflow`=0. Delay lines, pointers, occupancy and the row counter are all cleared.
- Reset asserted mid-operation discards in-flight and buffered rows. The first `in_valid` after deassertion is treated as a fresh row 0.
- Latency: `in_valid` in cycle c gives `out_valid` in cycle c+COLS when the FIFO was empty.
- Throughput: one row per cycle sustained while `out_ready` is held high.
- `out_row` and `out_valid` are registered, with no combinational path from `out_ready`.
- `tile_done` is registered and asserted in the cycle after the popping handshake.

## Test plan

- Single row, COLS=4: `in_valid` in cycle 10; columns 0..3 = 0x0011, 0x0022, 0x0033, 0x0044 in cycles 10..13. Expect `out_valid` in cycle 14 with `out_row` = {0x0044,0x0033,0x0022,0x0011} and `busy` high in cycles 11..14.
- Back-to-back: four rows with `in_valid` in cycles 10..13 and `out_ready`=1. Expect `out_valid` in cycles 14..17, rows in order, and `tile_done` pulse in cycle 18.
- Backpressure/overflow: `out_ready`=0 and 5 rows pushed. Expect occupancy 4, the 5th row dropped, and `overflow`=1. Then raise `out_ready`: expect rows 1–4 out in order, with `overflow` still 1.
- Full plus simultaneous push/pop: with the FIFO full, hold `out_ready`=1 while a new row aligns. Expect the row accepted, `overflow` stays 0, and occupancy stays 4.
- Mid-operation reset: assert `reset`=0 in the cycle after row 2 aligns. Expect `out_valid`, `busy` and `overflow` at 0 immediately. A new row after release yields `out_valid` at +COLS cycles, and the row counter restarts.
- Pointer wrap: push and pop 10 rows with data 0x0100+k. Expect all rows out in order through the wrap, and `tile_done` after rows 4 and 8.
